// File: rtl/io_server_pkg.sv
// Shared widths and types for the instruction-IO server: RAM byte width,
// register-file address width, IO op codes and server FSM states.
package pkg_ram;
    localparam int RAM_BYTE_SIZE = 8;
endpackage

package pkg_reg;
    localparam int REG_ADDRW = 5;
endpackage

package pkg_io;
    localparam int TX_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IO_NOP      = 2'd0,
        IO_PUTC_IMM = 2'd1,
        IO_PUTC_REG = 2'd2,
        IO_GETC     = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PUSH    = 2'd2,
        WAIT_RX = 2'd3
    } io_state_t;
endpackage

// File: rtl/if_instr_io.sv
// Decoder-to-IO-server instruction interface: op code plus immediate
// character and register index operands.
interface if_instr_io;
    import pkg_io::*;

    op_t                          op;
    logic [pkg_ram::RAM_BYTE_SIZE-1:0] char_imm;
    logic [pkg_reg::REG_ADDRW-1:0]     char_reg;

    modport server (input op, char_imm, char_reg);
    modport client (output op, char_imm, char_reg);
endinterface

// File: rtl/io_server_tx_fifo.sv
// Synchronous TX character FIFO; head entry read straight from storage,
// no fall-through, push refused whenever full.
module io_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only observable after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/io_server.sv
// Control-unit side of the instruction-IO interface: putc via a TX FIFO, and
// getc into the register file when IO_GETC_EN is defined.
module io_server
    import pkg_io::*;
#(
    parameter int TX_DEPTH = TX_DEPTH_DEFAULT,
    parameter int CHARW    = pkg_ram::RAM_BYTE_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    if_instr_io.server                    instr,
    output logic                          busy,
    output logic [pkg_reg::REG_ADDRW-1:0] reg_raddr,
    input  logic [CHARW-1:0]              reg_rdata,
    output logic                          reg_we,
    output logic [pkg_reg::REG_ADDRW-1:0] reg_waddr,
    output logic [CHARW-1:0]              reg_wdata,
    output logic [CHARW-1:0]              tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    input  logic [CHARW-1:0]              rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready
);
    io_state_t        state_q, state_d;
    op_t              op_eff;
    logic [CHARW-1:0] char_q, char_d;
    logic             done;
    logic             fifo_push;
    logic [CHARW-1:0] fifo_push_data;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef IO_GETC_EN
    assign op_eff = instr.op;
`else
    logic unused_rx;
    assign unused_rx = ^{rx_data, rx_valid};
    assign op_eff    = (instr.op == IO_GETC) ? IO_NOP : instr.op;
`endif

    io_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (CHARW)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .full      (fifo_full),
        .pop       (tx_ready),
        .pop_data  (tx_data),
        .empty     (fifo_empty)
    );

    assign tx_valid = !fifo_empty;
    assign busy     = !rst && (op_eff != IO_NOP) && !done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        char_d         = char_q;
        done           = 1'b0;
        fifo_push      = 1'b0;
        fifo_push_data = instr.char_imm;
        reg_raddr      = '0;
        reg_we         = 1'b0;
        reg_waddr      = '0;
        reg_wdata      = '0;
        rx_ready       = 1'b0;

        // Everything is suppressed during reset so no push or write escapes it.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    case (op_eff)
                        IO_PUTC_IMM: begin
                            if (!fifo_full) begin
                                fifo_push = 1'b1;
                                done      = 1'b1;
                            end
                        end
                        IO_PUTC_REG: begin
                            reg_raddr = instr.char_reg;
                            state_d   = READ;
                        end
`ifdef IO_GETC_EN
                        IO_GETC: state_d = WAIT_RX;
`endif
                        default: ;
                    endcase
                end
                READ: begin
                    char_d  = reg_rdata;
                    state_d = PUSH;
                end
                PUSH: begin
                    fifo_push_data = char_q;
                    if (!fifo_full) begin
                        fifo_push = 1'b1;
                        done      = 1'b1;
                        state_d   = IDLE;
                    end
                end
`ifdef IO_GETC_EN
                WAIT_RX: begin
                    rx_ready = 1'b1;
                    if (rx_valid) begin
                        reg_we    = 1'b1;
                        reg_waddr = instr.char_reg;
                        reg_wdata = rx_data;
                        done      = 1'b1;
                        state_d   = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_server.sv
// Directed bench for io_server: table of putc vectors plus hand sequences for
// register putc, getc (either build of IO_GETC_EN) and mid-operation reset.
module tb_io_server;
    import pkg_io::*;

    localparam int CHARW = pkg_ram::RAM_BYTE_SIZE;
    localparam int RAW   = pkg_reg::REG_ADDRW;
    localparam int NVEC  = 16;

    typedef struct {
        op_t        op;
        logic [7:0] imm;
        logic       rdy;
        logic       exp_busy;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic [RAW-1:0]   reg_raddr;
    logic [CHARW-1:0] reg_rdata = '0;
    logic             reg_we;
    logic [RAW-1:0]   reg_waddr;
    logic [CHARW-1:0] reg_wdata;
    logic [CHARW-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [CHARW-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    int checks   = 0;
    int failures = 0;
    int we_pulses = 0;
    logic [7:0] popped[$];
    logic [7:0] expected_stream[$];
    logic [CHARW-1:0] regs [32];
    vec_t vecs [NVEC];

    if_instr_io instr_if ();

    io_server dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr_if),
        .busy      (busy),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    always #5 clk = ~clk;

    // Register file with one-cycle read latency.
    always @(posedge clk) reg_rdata <= regs[reg_raddr];

    // UART side: record every character handed over, and count write pulses.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) popped.push_back(tx_data);
        if (reg_we) we_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input op_t op, input logic [7:0] imm, input logic [RAW-1:0] creg);
        instr_if.op       = op;
        instr_if.char_imm = imm;
        instr_if.char_reg = creg;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = CHARW'(i);
        regs[5] = 8'h7A;

        vecs[0]  = '{IO_PUTC_IMM, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{IO_NOP,      8'h00, 1'b1, 1'b0, 1'b1, 8'h41};
        vecs[2]  = '{IO_NOP,      8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{IO_PUTC_IMM, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{IO_PUTC_IMM, 8'h31, 1'b0, 1'b0, 1'b1, 8'h30};
        vecs[5]  = '{IO_PUTC_IMM, 8'h32, 1'b0, 1'b0, 1'b1, 8'h30};
        vecs[6]  = '{IO_PUTC_IMM, 8'h33, 1'b0, 1'b0, 1'b1, 8'h30};
        vecs[7]  = '{IO_PUTC_IMM, 8'h34, 1'b0, 1'b1, 1'b1, 8'h30};
        vecs[8]  = '{IO_PUTC_IMM, 8'h34, 1'b0, 1'b1, 1'b1, 8'h30};
        vecs[9]  = '{IO_PUTC_IMM, 8'h34, 1'b1, 1'b1, 1'b1, 8'h30};
        vecs[10] = '{IO_PUTC_IMM, 8'h34, 1'b0, 1'b0, 1'b1, 8'h31};
        vecs[11] = '{IO_NOP,      8'h00, 1'b1, 1'b0, 1'b1, 8'h31};
        vecs[12] = '{IO_NOP,      8'h00, 1'b1, 1'b0, 1'b1, 8'h32};
        vecs[13] = '{IO_NOP,      8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
        vecs[14] = '{IO_NOP,      8'h00, 1'b1, 1'b0, 1'b1, 8'h34};
        vecs[15] = '{IO_NOP,      8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

        expected_stream = '{8'h41, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h7A, 8'h60};

        // Reset with an op pending: busy must stay low and nothing is pushed.
        rst = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        set_op(IO_PUTC_IMM, 8'hEE, '0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("busy_in_reset", 32'(busy), 32'd0);

        next_cycle();
        rst = 1'b0;
        set_op(IO_NOP, 8'h00, '0);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_raddr", 32'(reg_raddr), 32'd0);
        check("rst_waddr", 32'(reg_waddr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);

        // Immediate putc, FIFO fill to full, refused push under simultaneous pop.
        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            set_op(vecs[i].op, vecs[i].imm, '0);
            tx_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
        end

        // Register putc: address in cycle 0, two stall cycles, char out after done.
        next_cycle();
        set_op(IO_PUTC_REG, 8'h00, RAW'(5));
        tx_ready = 1'b0;
        @(negedge clk);
        check("preg_raddr", 32'(reg_raddr), 32'd5);
        check("preg_busy0", 32'(busy), 32'd1);
        next_cycle();
        @(negedge clk);
        check("preg_busy1", 32'(busy), 32'd1);
        next_cycle();
        @(negedge clk);
        check("preg_done", 32'(busy), 32'd0);
        check("preg_valid_at_done", 32'(tx_valid), 32'd0);
        next_cycle();
        set_op(IO_NOP, 8'h00, '0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("preg_valid", 32'(tx_valid), 32'd1);
        check("preg_data", 32'(tx_data), 32'h7A);
        next_cycle();
        tx_ready = 1'b0;
        @(negedge clk);
        check("preg_drained", 32'(tx_valid), 32'd0);

`ifdef IO_GETC_EN
        // getc: ten stall cycles, then a single write pulse.
        next_cycle();
        set_op(IO_GETC, 8'h00, RAW'(3));
        rx_data = 8'h55;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            check($sformatf("getc_busy%0d", i), 32'(busy), 32'd1);
            check($sformatf("getc_we%0d", i), 32'(reg_we), 32'd0);
            if (i > 0) check($sformatf("getc_rxrdy%0d", i), 32'(rx_ready), 32'd1);
        end
        next_cycle();
        rx_valid = 1'b1;
        rx_data  = 8'h0D;
        @(negedge clk);
        check("getc_done", 32'(busy), 32'd0);
        check("getc_we", 32'(reg_we), 32'd1);
        check("getc_waddr", 32'(reg_waddr), 32'd3);
        check("getc_wdata", 32'(reg_wdata), 32'h0D);
        next_cycle();
        set_op(IO_NOP, 8'h00, '0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("getc_we_after", 32'(reg_we), 32'd0);
        check("getc_rxrdy_after", 32'(rx_ready), 32'd0);
        check("getc_pulses", 32'(we_pulses), 32'd1);
`else
        // getc disabled: behaves as a no-op and never touches the register file.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_op(IO_GETC, 8'h00, RAW'(3));
            rx_valid = 1'b1;
            rx_data  = 8'h0D;
            @(negedge clk);
            check($sformatf("nogetc_busy%0d", i), 32'(busy), 32'd0);
            check($sformatf("nogetc_we%0d", i), 32'(reg_we), 32'd0);
            check($sformatf("nogetc_rxrdy%0d", i), 32'(rx_ready), 32'd0);
            check($sformatf("nogetc_wdata%0d", i), 32'(reg_wdata), 32'd0);
        end
        next_cycle();
        set_op(IO_NOP, 8'h00, '0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("nogetc_pulses", 32'(we_pulses), 32'd0);
`endif

        // Reset while in PUSH with two characters buffered.
        next_cycle();
        tx_ready = 1'b0;
        set_op(IO_PUTC_IMM, 8'h50, '0);
        @(negedge clk);
        check("mid_push50", 32'(busy), 32'd0);
        next_cycle();
        set_op(IO_PUTC_IMM, 8'h51, '0);
        @(negedge clk);
        check("mid_push51", 32'(busy), 32'd0);
        next_cycle();
        set_op(IO_PUTC_REG, 8'h00, RAW'(5));
        @(negedge clk);
        check("mid_idle_busy", 32'(busy), 32'd1);
        next_cycle();
        @(negedge clk);
        check("mid_read_busy", 32'(busy), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        next_cycle();
        rst = 1'b0;
        set_op(IO_NOP, 8'h00, '0);
        @(negedge clk);
        check("post_rst_valid", 32'(tx_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_raddr", 32'(reg_raddr), 32'd0);
        next_cycle();
        set_op(IO_PUTC_IMM, 8'h60, '0);
        @(negedge clk);
        check("post_rst_push_busy", 32'(busy), 32'd0);
        check("post_rst_push_valid", 32'(tx_valid), 32'd0);
        next_cycle();
        set_op(IO_NOP, 8'h00, '0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("post_rst_head_valid", 32'(tx_valid), 32'd1);
        check("post_rst_head_data", 32'(tx_data), 32'h60);
        next_cycle();
        tx_ready = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 32'(tx_valid), 32'd0);

        // Whole TX stream: order kept, nothing lost or duplicated.
        check("stream_len", 32'(popped.size()), 32'(expected_stream.size()));
        for (int i = 0; i < expected_stream.size(); i++) begin
            if (i < popped.size())
                check($sformatf("stream%0d", i), 32'(popped[i]), 32'(expected_stream[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_server.md
Name: io_server

Overview:
- Server end of the instruction-IO interface; the control-unit side that executes IO ops issued by the decoder.
- Executes putc with an immediate or register operand by buffering the character in a small TX FIFO that feeds the UART transmitter.
- Optionally executes getc, writing a received byte into the register file.
- Stalls the CPU through `busy` while an op cannot complete.

Parameters:
- TX_DEPTH, 4: TX FIFO entries; power of two, at least 2.
- CHARW, pkg_ram::RAM_BYTE_SIZE: character width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- instr  if_instr_io.server  -  op, char_imm, char_reg from decoder
- busy  output  1  stall request to CPU control
- reg_raddr  output  pkg_reg::REG_ADDRW  register-file read address
- reg_rdata  input  CHARW  register-file read data; valid 1 cycle after address
- reg_we  output  1  register-file write enable
- reg_waddr  output  pkg_reg::REG_ADDRW  write address
- reg_wdata  output  CHARW  write data
- tx_data  output  CHARW  character to UART TX
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART TX accepts
- rx_data  input  CHARW  received character
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  server accepts rx_data

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high, one clock domain.
- Reset values:
  - State IDLE, FIFO empty.
  - tx_valid=0, reg_we=0, rx_ready=0, reg_raddr=0, reg_waddr=0, reg_wdata=0.
  - busy=0 while rst=1.
- Op protocol:
  - Decoder holds op, char_imm and char_reg stable while busy=1.
  - Op completes in the first cycle with busy=0 and op!=IO_NOP (internal `done`).
  - busy = (op!=IO_NOP) && !done, combinational.
  - The next cycle may present a new op.
- IO_NOP: no action; busy=0.
- IO_PUTC_IMM (IDLE):
  - FIFO not full: push char_imm, done same cycle; latency 0 stall cycles.
  - FIFO full: busy=1, stay IDLE, retry each cycle.
- IO_PUTC_REG:
  - IDLE: reg_raddr=char_reg, busy=1, go READ.
  - READ: latch reg_rdata into char_q, busy=1, go PUSH.
  - PUSH: if not full, push char_q, done, go IDLE; else busy=1, stay.
  - Minimum 2 stall cycles.
- IO_GETC:
  - IDLE: go WAIT_RX, busy=1.
  - WAIT_RX: rx_ready=1.
  - On rx_valid: reg_we=1, reg_waddr=char_reg, reg_wdata=rx_data, done, go IDLE.
  - reg_we is a single-cycle pulse.
- States: IDLE, READ, PUSH, WAIT_RX; encoded as enum.
- Unknown op value: treated as IO_NOP.
- TX FIFO:
  - tx_valid = !empty; tx_data = head entry, registered, no fall-through.
  - A push into an empty FIFO appears on tx_data the next cycle.
  - Pop on tx_valid && tx_ready.
  - Push refused when full even if a pop occurs the same cycle.
  - Push and pop in the same non-full, non-empty cycle: count unchanged.
  - Pointers wrap modulo TX_DEPTH; count width $clog2(TX_DEPTH)+1.
- rst mid-operation: FSM returns to IDLE and the FIFO is flushed; buffered characters are lost.

Optional Feature:
- Macro: IO_GETC_EN.
- Defined: IO_GETC supported as above, WAIT_RX state present.
- Undefined:
  - IO_GETC treated as IO_NOP (busy=0).
  - rx_ready tied 0.
  - reg_we tied 0; reg_waddr and reg_wdata tied 0.
  - rx_data and rx_valid ignored.

Decomposition:
- pkg_io:
  - op_t with IO_NOP, IO_PUTC_IMM, IO_PUTC_REG, IO_GETC.
  - io_state_t.
  - TX_DEPTH default constant.
- Widths come from pkg_ram and pkg_reg.
- Sub-module io_tx_fifo: synchronous FIFO with push/full and pop/empty, parameterised on depth and width.

Test Plan:
- Reset, then IO_PUTC_IMM 'A' (0x41) with tx_ready=1 → busy=0; next cycle tx_valid=1, tx_data=0x41; popped the following cycle.
- tx_ready=0, five IO_PUTC_IMM 0x30..0x34, TX_DEPTH=4 → first four complete with busy=0; fifth stalls busy=1 until tx_ready pulses once; output order 0x30..0x34.
- Reg 5 holds 0x7A, IO_PUTC_REG char_reg=5 → reg_raddr=5 in cycle 0; busy high 2 cycles; tx_data=0x7A one cycle after done.
- IO_GETC_EN defined, IO_GETC char_reg=3, rx_valid after 10 cycles with 0x0D → busy high 10 cycles; single reg_we pulse with waddr=3, wdata=0x0D. Without macro → busy=0, reg_we never asserted.
- FIFO full with tx_ready=1 and IO_PUTC_IMM presented → push refused that cycle (busy=1); accepted next cycle; no loss or duplication.
- rst asserted in PUSH with FIFO holding 2 entries → next cycle: IDLE, tx_valid=0, busy=0.
